if_fetch: RTL and testbench

//  Instruction-fetch stage: owns the PC, assembles 32-bit little-endian instructions from
//  the byte-wide memory port, and feeds if_pc/if_inst into the IF_ID register. Consumes the
//  ID-stage redirect (use_npc/npc_addr) and drives the IF stall request (stall[0] source).

---
 rtl/if_fetch_pkg.sv | 29 ++
 rtl/if_fetch_icache.sv | 55 +++++
 rtl/if_fetch.sv | 141 ++++++++++++++
 tb/tb_if_fetch.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: reset/bus constants,
// fetch FSM state encodings and the byte-lane helper.
package if_fetch_pkg;

  localparam logic        RstEnable   = 1'b1;
  localparam int          InstAddrBus = 32;
  localparam int          InstBus     = 32;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  typedef enum logic [2:0] {
    IF_S_I0   = 3'd0,
    IF_S_I1   = 3'd1,
    IF_S_I2   = 3'd2,
    IF_S_I3   = 3'd3,
    IF_S_W3   = 3'd4,
    IF_S_DONE = 3'd5
  } if_state_e;

  // Byte offset from pc issued in each issue state.
  function automatic logic [1:0] issue_offset(input if_state_e s);
    case (s)
      IF_S_I1: return 2'd1;
      IF_S_I2: return 2'd2;
      IF_S_I3: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/if_fetch_icache.sv
// if_icache: direct-mapped word cache for the fetch stage. Hit is combinational
// from the lookup pc; data/tag arrays are written on the clock, valid bits reset.
module if_icache
  import if_fetch_pkg::*;
#(
  parameter int CACHE_LINES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:2]        i_lookup_pc,
  output logic               o_hit,
  output logic [InstBus-1:0] o_data,
  input  logic               i_fill_en,
  input  logic [31:2]        i_fill_pc,
  input  logic [InstBus-1:0] i_fill_data
);

  localparam int IDX_W = $clog2(CACHE_LINES);
  localparam int TAG_W = 30 - IDX_W;

  logic [TAG_W-1:0]       r_tag  [CACHE_LINES];
  logic [InstBus-1:0]     r_data [CACHE_LINES];
  logic [CACHE_LINES-1:0] r_valid;

  logic [IDX_W-1:0] w_lookup_idx;
  logic [TAG_W-1:0] w_lookup_tag;
  logic [IDX_W-1:0] w_fill_idx;
  logic [TAG_W-1:0] w_fill_tag;

  assign w_lookup_idx = i_lookup_pc[IDX_W+1:2];
  assign w_lookup_tag = i_lookup_pc[31:IDX_W+2];
  assign w_fill_idx   = i_fill_pc[IDX_W+1:2];
  assign w_fill_tag   = i_fill_pc[31:IDX_W+2];

  assign o_hit  = r_valid[w_lookup_idx] && (r_tag[w_lookup_idx] == w_lookup_tag);
  assign o_data = r_data[w_lookup_idx];

  always_ff @(posedge clk) begin
    if (i_fill_en) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= i_fill_data;
    end
  end

  for (genvar gi = 0; gi < CACHE_LINES; gi++) begin : g_valid
    always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
        r_valid[gi] <= 1'b0;
      end else if (i_fill_en && (w_fill_idx == IDX_W'(gi))) begin
        r_valid[gi] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/if_fetch.sv
// if_fetch: owns the PC and assembles little-endian 32-bit instructions from a
// byte-wide memory port. Optional instruction cache enabled by IF_ICACHE_EN.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          CACHE_LINES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic [4:0]             stall,
  input  logic                   use_npc,
  input  logic [InstAddrBus-1:0] npc_addr,
  input  logic                   mem_busy,
  input  logic [7:0]             mem_din,
  output logic [InstAddrBus-1:0] mem_addr,
  output logic                   mem_req,
  output logic                   if_stall_req,
  output logic [InstAddrBus-1:0] if_pc,
  output logic [InstBus-1:0]     if_inst
);

  if_state_e              r_state;
  if_state_e              w_state_next;
  logic [InstAddrBus-1:0] r_pc;
  logic [InstBus-1:0]     r_buf;
  logic [InstBus-1:0]     w_buf_next;
  logic                   r_inflight;
  logic [1:0]             r_inflight_lane;

  logic               w_is_issue_state;
  logic               w_issue;
  logic               w_capture;
  logic               w_done;
  logic               w_hit;
  logic [InstBus-1:0] w_cache_data;
  logic               w_unused_stall;

  assign w_unused_stall = ^{stall[4:2], stall[0]};

  assign w_is_issue_state = (r_state == IF_S_I0) || (r_state == IF_S_I1) ||
                            (r_state == IF_S_I2) || (r_state == IF_S_I3);

`ifdef IF_ICACHE_EN
  logic w_cache_hit;
  logic w_fill_en;

  // A fill needs the last byte in flight and no redirect discarding it.
  assign w_fill_en = rdy && (rst != RstEnable) && !use_npc &&
                     (r_state == IF_S_W3) && r_inflight;

  if_icache #(
    .CACHE_LINES(CACHE_LINES)
  ) u_icache (
    .clk         (clk),
    .rst         (rst),
    .i_lookup_pc (r_pc[31:2]),
    .o_hit       (w_cache_hit),
    .o_data      (w_cache_data),
    .i_fill_en   (w_fill_en),
    .i_fill_pc   (r_pc[31:2]),
    .i_fill_data ({mem_din, r_buf[23:0]})
  );

  assign w_hit = (r_state == IF_S_I0) && w_cache_hit;
`else
  logic w_unused_cache_lines;
  assign w_unused_cache_lines = (CACHE_LINES == 0);
  assign w_hit        = 1'b0;
  assign w_cache_data = ZeroWord;
`endif

  // Redirect, reset, freeze and a cache hit all suppress a new memory read.
  assign w_issue   = w_is_issue_state && !mem_busy && !use_npc && rdy &&
                     (rst != RstEnable) && !w_hit;
  assign w_capture = r_inflight && !use_npc;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state <= IF_S_I0;
    end else if (rdy) begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (use_npc) begin
      w_state_next = IF_S_I0;
    end else begin
      case (r_state)
        IF_S_I0: begin
          if (w_hit)          w_state_next = IF_S_DONE;
          else if (!mem_busy) w_state_next = IF_S_I1;
        end
        IF_S_I1:   if (!mem_busy) w_state_next = IF_S_I2;
        IF_S_I2:   if (!mem_busy) w_state_next = IF_S_I3;
        IF_S_I3:   if (!mem_busy) w_state_next = IF_S_W3;
        IF_S_W3:   w_state_next = IF_S_DONE;
        IF_S_DONE: if (!stall[1]) w_state_next = IF_S_I0;
        default:   w_state_next = IF_S_I0;
      endcase
    end
  end

  always_comb begin
    w_done       = (r_state == IF_S_DONE) && !use_npc && (rst != RstEnable);
    mem_req      = w_issue;
    mem_addr     = w_issue ? (r_pc + {30'd0, issue_offset(r_state)}) : ZeroWord;
    if_stall_req = !w_done;
    if_pc        = w_done ? r_pc : ZeroWord;
    if_inst      = w_done ? r_buf : ZeroWord;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_buf_next[gi*8 +: 8] =
        (w_capture && (r_inflight_lane == 2'(gi))) ? mem_din :
        (w_hit && !use_npc)                        ? w_cache_data[gi*8 +: 8] :
                                                     r_buf[gi*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_pc            <= RESET_PC;
      r_buf           <= ZeroWord;
      r_inflight      <= 1'b0;
      r_inflight_lane <= 2'd0;
    end else if (rdy) begin
      r_buf           <= w_buf_next;
      r_inflight      <= w_issue;
      r_inflight_lane <= issue_offset(r_state);
      if (use_npc) begin
        r_pc <= npc_addr;
      end else if ((r_state == IF_S_DONE) && !stall[1]) begin
        r_pc <= r_pc + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: byte assembly, redirect, memory contention,
// downstream stall, pc wrap, freeze and reset abort (plus cache hits with IF_ICACHE_EN).
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [4:0]  stall;
  logic        use_npc;
  logic [31:0] npc_addr;
  logic        mem_busy;
  logic [7:0]  mem_din;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        if_stall_req;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  int checks   = 0;
  int failures = 0;

  if_fetch #(
    .RESET_PC    (32'h0000_0000),
    .CACHE_LINES (64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .stall        (stall),
    .use_npc      (use_npc),
    .npc_addr     (npc_addr),
    .mem_busy     (mem_busy),
    .mem_din      (mem_din),
    .mem_addr     (mem_addr),
    .mem_req      (mem_req),
    .if_stall_req (if_stall_req),
    .if_pc        (if_pc),
    .if_inst      (if_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 8'h13;
      32'h0000_0004: return 8'h93;
      32'h0000_0006: return 8'hA0;
      32'h0000_0100: return 8'h37;
      32'h0000_0101: return 8'h12;
      32'h0000_0104: return 8'hEF;
      32'h0000_0106: return 8'hC0;
      32'hFFFF_FFFC: return 8'h6F;
      default:       return 8'h00;
    endcase
  endfunction

  // Read byte returned one cycle after the request; garbage when idle.
  always @(posedge clk) mem_din <= mem_req ? mem_byte(mem_addr) : 8'hEE;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Walks issue states from_k..3, then S_W3 and S_DONE, checking the result.
  task automatic issue_seq(input logic [31:0] base, input int from_k,
                           input logic [31:0] exp_inst);
    for (int k = from_k; k < 4; k++) begin
      step(); #1;
      chk("issue_req", {31'd0, mem_req}, 32'd1);
      chk("issue_addr", mem_addr, base + k);
    end
    step(); #1;
    chk("w3_stall_req", {31'd0, if_stall_req}, 32'd1);
    chk("w3_inst_bubble", if_inst, 32'd0);
    step(); #1;
    chk("done_inst", if_inst, exp_inst);
    chk("done_pc", if_pc, base);
    chk("done_stall_req", {31'd0, if_stall_req}, 32'd0);
    chk("done_no_req", {31'd0, mem_req}, 32'd0);
    $display("fetch pc=%h inst=%h", if_pc, if_inst);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; stall = 5'd0; use_npc = 1'b0;
    npc_addr = 32'd0; mem_busy = 1'b0;

    // Reset state
    step(); #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_stall_req", {31'd0, if_stall_req}, 32'd1);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);

    // Plain fetch at 0: bytes 13 00 00 00
    step(); rst = 1'b0; #1;
    chk("t1_req0", {31'd0, mem_req}, 32'd1);
    chk("t1_addr0", mem_addr, 32'h0);
    issue_seq(32'h0, 1, 32'h0000_0013);

    // pc+4, then redirect during S_I2
    step(); #1;
    chk("t1_next_addr", mem_addr, 32'h4);
    step(); #1;
    chk("t2_addr5", mem_addr, 32'h5);
    step(); use_npc = 1'b1; npc_addr = 32'h100; #1;
    chk("t2_redir_inst", if_inst, 32'd0);
    chk("t2_redir_req", {31'd0, mem_req}, 32'd0);
    chk("t2_redir_stall", {31'd0, if_stall_req}, 32'd1);
    step(); use_npc = 1'b0; #1;
    chk("t2_new_addr", mem_addr, 32'h100);
    issue_seq(32'h100, 1, 32'h0000_1237);

    // Downstream stall held in S_DONE for 4 cycles
    stall = 5'b00010;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("t4_hold_inst", if_inst, 32'h0000_1237);
      chk("t4_hold_pc", if_pc, 32'h100);
      chk("t4_hold_req", {31'd0, mem_req}, 32'd0);
    end
    step(); stall = 5'd0; #1;
    chk("t4_release_inst", if_inst, 32'h0000_1237);

    // rdy=0 freezes S_I0 at 0x104
    step(); rdy = 1'b0; #1;
    chk("frz_req0", {31'd0, mem_req}, 32'd0);
    step(); #1;
    chk("frz_req1", {31'd0, mem_req}, 32'd0);
    step(); rdy = 1'b1; #1;
    chk("frz_resume_req", {31'd0, mem_req}, 32'd1);
    chk("frz_resume_addr", mem_addr, 32'h104);

    // Memory contention for 3 cycles in S_I1
    step(); mem_busy = 1'b1; #1;
    chk("t3_busy_req0", {31'd0, mem_req}, 32'd0);
    step(); #1;
    chk("t3_busy_req1", {31'd0, mem_req}, 32'd0);
    step(); #1;
    chk("t3_busy_req2", {31'd0, mem_req}, 32'd0);
    step(); mem_busy = 1'b0; #1;
    chk("t3_resume_addr", mem_addr, 32'h105);
    issue_seq(32'h104, 2, 32'h00C0_00EF);

    // Redirect coinciding with S_DONE beats pc+4; target wraps
    use_npc = 1'b1; npc_addr = 32'hFFFF_FFFC; #1;
    chk("t5_done_redir_inst", if_inst, 32'd0);
    step(); use_npc = 1'b0; #1;
    chk("t5_addr", mem_addr, 32'hFFFF_FFFC);
    issue_seq(32'hFFFF_FFFC, 1, 32'h0000_006F);
    step(); #1;
`ifdef IF_ICACHE_EN
    chk("wrap_hit_no_req", {31'd0, mem_req}, 32'd0);
`else
    chk("wrap_req", {31'd0, mem_req}, 32'd1);
    chk("wrap_addr", mem_addr, 32'h0);
`endif

    // Reset mid-fetch aborts immediately
    step(); rst = 1'b1; #1;
    chk("rstmid_req", {31'd0, mem_req}, 32'd0);
    chk("rstmid_inst", if_inst, 32'd0);
    chk("rstmid_stall", {31'd0, if_stall_req}, 32'd1);
    step(); #1;
    chk("rstmid_req2", {31'd0, mem_req}, 32'd0);
    step(); rst = 1'b0; #1;
    chk("rstmid_restart_req", {31'd0, mem_req}, 32'd1);
    chk("rstmid_restart_addr", mem_addr, 32'h0);

`ifdef IF_ICACHE_EN
    // First pass fills 0x0 and 0x4; second pass hits in two cycles each
    issue_seq(32'h0, 1, 32'h0000_0013);
    issue_seq(32'h4, 0, 32'h00A0_0093);
    use_npc = 1'b1; npc_addr = 32'h0;
    for (int p = 0; p < 2; p++) begin
      step(); use_npc = 1'b0; #1;
      chk("c_hit_no_req", {31'd0, mem_req}, 32'd0);
      chk("c_hit_stall", {31'd0, if_stall_req}, 32'd1);
      step(); #1;
      chk("c_hit_inst", if_inst, (p == 0) ? 32'h0000_0013 : 32'h00A0_0093);
      chk("c_hit_pc", if_pc, (p == 0) ? 32'h0 : 32'h4);
      chk("c_hit_done_no_req", {31'd0, mem_req}, 32'd0);
      $display("cached fetch pc=%h inst=%h", if_pc, if_inst);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
